// File: rtl/mips_lsu_pkg.sv
// +----------------------------------------------------------------------+
// | mips_lsu_pkg : shared encodings and helpers for the MIPS load/store    |
// | unit. Rev 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

package mips_lsu_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [1:0] SZ_DWORD = 2'b11;

  localparam int BYTE_W = 8;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } lsu_state_e;

  function automatic int lane_count(input int data_w);
    return data_w / BYTE_W;
  endfunction

  function automatic int size_bytes(input logic [1:0] sz);
    return 32'd1 << sz;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mips_lsu_align.sv
// +----------------------------------------------------------------------+
// | mips_lsu_align : alignment check, store lane steering and load lane    |
// | extraction with sign/zero extension (big-endian). Rev 1.0              |
// +----------------------------------------------------------------------+
`default_nettype none

module mips_lsu_align
  import mips_lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_W  = 2
) (
  input  logic [1:0]          st_size,
  input  logic [OFF_W-1:0]    st_off,
  input  logic [DATA_W-1:0]   st_wdata,
  output logic                st_aligned,
  output logic [DATA_W/8-1:0] st_be,
  output logic [DATA_W-1:0]   st_wdata_lane,
  input  logic [1:0]          ld_size,
  input  logic [OFF_W-1:0]    ld_off,
  input  logic                ld_signext,
  input  logic [DATA_W-1:0]   ld_rdata,
  output logic [DATA_W-1:0]   ld_data
);

  localparam int NB = lane_count(DATA_W);

  always_comb begin
    int st_n;
    st_n = size_bytes(st_size);
    if (st_n > NB) st_n = NB;

    case (st_size)
      SZ_BYTE: st_aligned = 1'b1;
      SZ_HALF: st_aligned = (st_off[0] == 1'b0);
      SZ_WORD: st_aligned = (st_off[1:0] == 2'b00);
      default: st_aligned = (NB == 8) && (st_off == '0);
    endcase

    // Lane o is byte offset o; offset 0 sits in the most significant lane.
    st_be         = '0;
    st_wdata_lane = '0;
    for (int o = 0; o < NB; o++) begin
      if (o >= int'(st_off) && o < int'(st_off) + st_n) st_be[NB-1-o] = 1'b1;
      st_wdata_lane[DATA_W-1-BYTE_W*o -: BYTE_W] =
        st_wdata[BYTE_W*(st_n-1-(o & (st_n-1))) +: BYTE_W];
    end
  end

  always_comb begin
    int            ld_n;
    logic [DATA_W-1:0] raw;
    logic          sign;
    ld_n = size_bytes(ld_size);
    if (ld_n > NB) ld_n = NB;

    raw = '0;
    for (int k = 0; k < NB; k++) begin
      if (k < ld_n && int'(ld_off) + k < NB)
        raw[BYTE_W*(ld_n-1-k) +: BYTE_W] = ld_rdata[DATA_W-1-BYTE_W*(int'(ld_off)+k) -: BYTE_W];
    end

    sign    = ld_signext & raw[BYTE_W*ld_n-1];
    ld_data = raw;
    for (int j = 0; j < DATA_W; j++) begin
      if (j >= BYTE_W*ld_n) ld_data[j] = sign;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mips_lsu.sv
// +----------------------------------------------------------------------+
// | mips_lsu : M-stage load/store unit with req/ack memory handshake.      |
// | Optional watchdog enabled by MIPS_LSU_TIMEOUT_EN. Rev 1.0              |
// +----------------------------------------------------------------------+
`default_nettype none

module mips_lsu
  import mips_lsu_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                req_valid,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_signext,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [4:0]          req_rd,
  output logic                stall,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_data,
  output logic [4:0]          resp_rd,
  output logic                misalign,
  output logic                bus_err,
  output logic                mem_req,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int NB    = lane_count(DATA_W);
  localparam int OFF_W = $clog2(NB);

  if (!(DATA_W == 32 || DATA_W == 64) || MAX_WAIT < 1 || MAX_WAIT > 65535) begin : g_bad_param
    $error("mips_lsu: illegal parameter value");
  end

  lsu_state_e state_q, state_d;

  logic                we_q, we_d;
  logic [1:0]          size_q, size_d;
  logic [OFF_W-1:0]    off_q, off_d;
  logic                signext_q, signext_d;
  logic [4:0]          rd_q, rd_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W/8-1:0] mem_be_q, mem_be_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_data_q, resp_data_d;
  logic [4:0]          resp_rd_q, resp_rd_d;
  logic                misalign_q, misalign_d;
  logic                bus_err_q, bus_err_d;

  logic                aligned_w;
  logic [DATA_W/8-1:0] st_be_w;
  logic [DATA_W-1:0]   st_wdata_w;
  logic [DATA_W-1:0]   ld_data_w;
  logic                accept_w;
  logic                timeout_w;

  mips_lsu_align #(
    .DATA_W (DATA_W),
    .OFF_W  (OFF_W)
  ) u_align (
    .st_size       (req_size),
    .st_off        (req_addr[OFF_W-1:0]),
    .st_wdata      (req_wdata),
    .st_aligned    (aligned_w),
    .st_be         (st_be_w),
    .st_wdata_lane (st_wdata_w),
    .ld_size       (size_q),
    .ld_off        (off_q),
    .ld_signext    (signext_q),
    .ld_rdata      (mem_rdata),
    .ld_data       (ld_data_w)
  );

  assign accept_w = (state_q == IDLE) && en && req_valid && aligned_w;

`ifdef MIPS_LSU_TIMEOUT_EN
  localparam int CNT_W = (MAX_WAIT > 255) ? 16 : 8;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (accept_w)                        cnt_d = '0;
    else if (state_q == ACCESS && en)    cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // An ack in the final allowed cycle still completes the access.
  assign timeout_w = (state_q == ACCESS) && en && !mem_ack &&
                     (cnt_q == CNT_W'(MAX_WAIT - 1));
`else
  assign timeout_w = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_w) state_d = ACCESS;
      ACCESS:  if (en && (mem_ack || timeout_w)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall   = (state_q == ACCESS) || accept_w;
    mem_req = (state_q == ACCESS);
  end

  always_comb begin
    we_d         = we_q;
    size_d       = size_q;
    off_d        = off_q;
    signext_d    = signext_q;
    rd_d         = rd_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_rd_d    = resp_rd_q;
    misalign_d   = misalign_q;
    bus_err_d    = bus_err_q;

    if (en) begin
      resp_valid_d = 1'b0;
      misalign_d   = 1'b0;
      bus_err_d    = 1'b0;

      if (state_q == IDLE && req_valid) begin
        if (aligned_w) begin
          we_d        = req_we;
          size_d      = req_size;
          off_d       = req_addr[OFF_W-1:0];
          signext_d   = req_signext;
          rd_d        = req_rd;
          mem_addr_d  = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          mem_be_d    = req_we ? st_be_w : '0;
          mem_wdata_d = req_we ? st_wdata_w : '0;
        end else begin
          misalign_d = 1'b1;
        end
      end

      if (state_q == ACCESS) begin
        if (mem_ack) begin
          if (!we_q) begin
            resp_valid_d = 1'b1;
            resp_data_d  = ld_data_w;
            resp_rd_d    = rd_q;
          end
        end else if (timeout_w) begin
          bus_err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q         <= 1'b0;
      size_q       <= SZ_BYTE;
      off_q        <= '0;
      signext_q    <= 1'b0;
      rd_q         <= '0;
      mem_addr_q   <= '0;
      mem_be_q     <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_rd_q    <= '0;
      misalign_q   <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      we_q         <= we_d;
      size_q       <= size_d;
      off_q        <= off_d;
      signext_q    <= signext_d;
      rd_q         <= rd_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_rd_q    <= resp_rd_d;
      misalign_q   <= misalign_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_rd    = resp_rd_q;
  assign misalign   = misalign_q;
  assign bus_err    = bus_err_q;
  assign mem_be     = mem_be_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mips_lsu.sv
// Self-checking bench for mips_lsu: a 32-bit and a 64-bit instance share the
// request bus; sel64 routes valid/ack to one of them.
`timescale 1ns/1ps
`default_nettype none

module tb_mips_lsu;

  logic        clk = 1'b0;
  logic        rst, en, req_valid, req_we, req_signext, mem_ack, sel64;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [63:0] req_wdata, mem_rdata;
  logic [4:0]  req_rd;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  logic        rv_a, ack_a, rv_b, ack_b;
  assign rv_a  = req_valid & ~sel64;
  assign ack_a = mem_ack   & ~sel64;
  assign rv_b  = req_valid &  sel64;
  assign ack_b = mem_ack   &  sel64;

  logic        stall_a, resp_valid_a, misalign_a, bus_err_a, mem_req_a;
  logic [31:0] resp_data_a, mem_addr_a, mem_wdata_a;
  logic [4:0]  resp_rd_a;
  logic [3:0]  mem_be_a;
  logic        stall_b, resp_valid_b, misalign_b, bus_err_b, mem_req_b;
  logic [63:0] resp_data_b, mem_wdata_b;
  logic [31:0] mem_addr_b;
  logic [4:0]  resp_rd_b;
  logic [7:0]  mem_be_b;

  mips_lsu #(.DATA_W(32), .ADDR_W(32), .MAX_WAIT(4)) dut_a (
    .clk(clk), .rst(rst), .en(en), .req_valid(rv_a), .req_we(req_we),
    .req_size(req_size), .req_signext(req_signext), .req_addr(req_addr),
    .req_wdata(req_wdata[31:0]), .req_rd(req_rd), .stall(stall_a),
    .resp_valid(resp_valid_a), .resp_data(resp_data_a), .resp_rd(resp_rd_a),
    .misalign(misalign_a), .bus_err(bus_err_a), .mem_req(mem_req_a),
    .mem_be(mem_be_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
    .mem_ack(ack_a), .mem_rdata(mem_rdata[31:0]));

  mips_lsu #(.DATA_W(64), .ADDR_W(32), .MAX_WAIT(4)) dut_b (
    .clk(clk), .rst(rst), .en(en), .req_valid(rv_b), .req_we(req_we),
    .req_size(req_size), .req_signext(req_signext), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd), .stall(stall_b),
    .resp_valid(resp_valid_b), .resp_data(resp_data_b), .resp_rd(resp_rd_b),
    .misalign(misalign_b), .bus_err(bus_err_b), .mem_req(mem_req_b),
    .mem_be(mem_be_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_ack(ack_b), .mem_rdata(mem_rdata));

  // Views of whichever instance is selected.
  logic        v_stall, v_resp_valid, v_misalign, v_bus_err, v_mem_req;
  logic [63:0] v_resp_data, v_mem_wdata;
  logic [31:0] v_mem_addr;
  logic [7:0]  v_mem_be;
  logic [4:0]  v_resp_rd;
  assign v_stall      = sel64 ? stall_b      : stall_a;
  assign v_resp_valid = sel64 ? resp_valid_b : resp_valid_a;
  assign v_misalign   = sel64 ? misalign_b   : misalign_a;
  assign v_bus_err    = sel64 ? bus_err_b    : bus_err_a;
  assign v_mem_req    = sel64 ? mem_req_b    : mem_req_a;
  assign v_resp_data  = sel64 ? resp_data_b  : {32'd0, resp_data_a};
  assign v_mem_wdata  = sel64 ? mem_wdata_b  : {32'd0, mem_wdata_a};
  assign v_mem_addr   = sel64 ? mem_addr_b   : mem_addr_a;
  assign v_mem_be     = sel64 ? mem_be_b     : {4'd0, mem_be_a};
  assign v_resp_rd    = sel64 ? resp_rd_b    : resp_rd_a;

  // ---------------- reference model (byte-array arithmetic) ----------------
  function automatic bit m_aligned(input int nb, input logic [1:0] sz, input logic [31:0] a);
    int n;
    n = 1 << sz;
    if (n > nb) return 1'b0;
    return (int'(a[2:0]) % n) == 0;
  endfunction

  function automatic logic [63:0] m_be(input int nb, input logic [1:0] sz, input logic [31:0] a);
    int n, off;
    n   = 1 << sz;
    off = int'(a[2:0]) % nb;
    return ((64'd1 << n) - 64'd1) << (nb - off - n);
  endfunction

  function automatic logic [63:0] m_wdata(input int nb, input logic [1:0] sz, input logic [63:0] wd);
    int n;
    logic [63:0] field, r;
    n     = 1 << sz;
    field = (n == 8) ? wd : (wd & ((64'd1 << (8*n)) - 64'd1));
    r     = '0;
    for (int i = 0; i < nb / n; i++) r = (n == 8) ? field : ((r << (8*n)) | field);
    return r;
  endfunction

  function automatic logic [63:0] m_load(input int nb, input logic [1:0] sz, input bit sx,
                                         input logic [31:0] a, input logic [63:0] rdata);
    int n, off;
    logic [63:0] mask, v;
    n    = 1 << sz;
    off  = int'(a[2:0]) % nb;
    mask = (n == 8) ? {64{1'b1}} : ((64'd1 << (8*n)) - 64'd1);
    v    = (rdata >> (8*(nb - off - n))) & mask;
    if (sx && v[8*n-1]) v = v | ~mask;
    if (nb == 4) v = v & 64'h0000_0000_FFFF_FFFF;
    return v;
  endfunction

  // One complete operation with a given number of wait states before ack.
  task automatic run_op(input bit b64, input bit we, input logic [1:0] sz, input bit sx,
                        input logic [31:0] addr, input logic [63:0] wd, input logic [4:0] rd,
                        input logic [63:0] rdata, input int waits, input string tag);
    int          nb;
    bit          ok;
    int          stall_cycles;
    logic [63:0] rdv, exp_be, exp_wd, exp_ld;
    nb     = b64 ? 8 : 4;
    rdv    = b64 ? rdata : {32'd0, rdata[31:0]};
    ok     = m_aligned(nb, sz, addr);
    exp_be = we ? m_be(nb, sz, addr) : 64'd0;
    exp_wd = m_wdata(nb, sz, wd);
    exp_ld = m_load(nb, sz, sx, addr, rdv);

    @(negedge clk);
    sel64 = b64; en = 1'b1; mem_ack = 1'b0; req_valid = 1'b1; req_we = we;
    req_size = sz; req_signext = sx; req_addr = addr; req_wdata = wd; req_rd = rd;
    #1;
    vectors++;
    if (v_stall !== ok) begin
      miscompares++; $display("FAIL %s accept_stall: got %b want %b", tag, v_stall, ok);
    end
    stall_cycles = ok ? 1 : 0;
    @(posedge clk);

    if (!ok) begin
      @(negedge clk); req_valid = 1'b0; #1;
      vectors++;
      if (v_misalign !== 1'b1 || v_mem_req !== 1'b0 || v_stall !== 1'b0) begin
        miscompares++;
        $display("FAIL %s misalign_pulse: got mis=%b req=%b stall=%b want 1 0 0", tag, v_misalign, v_mem_req, v_stall);
      end
      @(negedge clk);
      vectors++;
      if (v_misalign !== 1'b0 || v_mem_req !== 1'b0) begin
        miscompares++; $display("FAIL %s misalign_clear: got mis=%b req=%b want 0 0", tag, v_misalign, v_mem_req);
      end
      return;
    end

    for (int w = 0; w <= waits; w++) begin
      @(negedge clk);
      vectors++;
      if (v_mem_req !== 1'b1) begin
        miscompares++; $display("FAIL %s mem_req: got %b want 1 (wait %0d)", tag, v_mem_req, w);
      end
      if (w == 0) begin
        vectors++;
        if (v_mem_addr !== (addr & ~(nb - 1)) || v_mem_be !== exp_be[7:0]) begin
          miscompares++;
          $display("FAIL %s mem_addr_be: got %h/%b want %h/%b", tag, v_mem_addr, v_mem_be, addr & ~(nb - 1), exp_be[7:0]);
        end
        if (we) begin
          vectors++;
          if (v_mem_wdata !== exp_wd) begin
            miscompares++; $display("FAIL %s mem_wdata: got %h want %h", tag, v_mem_wdata, exp_wd);
          end
        end
      end
      if (v_stall === 1'b1) stall_cycles++;
      mem_ack   = (w == waits);
      mem_rdata = (w == waits) ? rdv : {$urandom, $urandom};
      @(posedge clk);
    end

    @(negedge clk); mem_ack = 1'b0; req_valid = 1'b0; #1;
    vectors++;
    if (v_resp_valid !== !we) begin
      miscompares++; $display("FAIL %s resp_valid: got %b want %b", tag, v_resp_valid, !we);
    end
    if (!we) begin
      vectors++;
      if (v_resp_data !== exp_ld || v_resp_rd !== rd) begin
        miscompares++;
        $display("FAIL %s resp_data_rd: got %h/%0d want %h/%0d", tag, v_resp_data, v_resp_rd, exp_ld, rd);
      end
    end
    vectors++;
    if (v_stall !== 1'b0 || v_mem_req !== 1'b0 || stall_cycles != waits + 2) begin
      miscompares++;
      $display("FAIL %s stall_release: got stall=%b req=%b cycles=%0d want 0 0 %0d", tag, v_stall, v_mem_req, stall_cycles, waits + 2);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b1; req_valid = 1'b0; mem_ack = 1'b0; sel64 = 1'b0;
    req_we = 1'b0; req_size = 2'b00; req_signext = 1'b0; req_addr = '0;
    req_wdata = '0; req_rd = '0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({stall_a, resp_valid_a, misalign_a, bus_err_a, mem_req_a} !== 5'b0) begin
      miscompares++; $display("FAIL reset_ctrl_a: got %b want 00000", {stall_a, resp_valid_a, misalign_a, bus_err_a, mem_req_a});
    end
    vectors++;
    if (resp_data_a !== 32'd0 || resp_rd_a !== 5'd0) begin
      miscompares++; $display("FAIL reset_resp_a: got %h/%0d want 0/0", resp_data_a, resp_rd_a);
    end
    vectors++;
    if (mem_be_a !== 4'd0 || mem_addr_a !== 32'd0 || mem_wdata_a !== 32'd0) begin
      miscompares++; $display("FAIL reset_mem_a: got %b/%h/%h want 0", mem_be_a, mem_addr_a, mem_wdata_a);
    end
    vectors++;
    if ({stall_b, resp_valid_b, misalign_b, bus_err_b, mem_req_b, resp_data_b, resp_rd_b,
         mem_be_b, mem_addr_b, mem_wdata_b} !== '0) begin
      miscompares++; $display("FAIL reset_all_b: got nonzero want all zero");
    end
    rst = 1'b0;
  endtask

  task automatic test_spec_vectors();
    run_op(1'b0, 1'b0, 2'b00, 1'b1, 32'h1001, 64'd0, 5'd7, 64'h12F45678, 3, "lb_signed");
    vectors++;
    if (resp_data_a !== 32'hFFFFFFF4) begin
      miscompares++; $display("FAIL lb_signed_value: got %h want FFFFFFF4", resp_data_a);
    end
    run_op(1'b0, 1'b1, 2'b01, 1'b0, 32'h2002, 64'h0000ABCD, 5'd0, 64'd0, 1, "sh_lanes");
    run_op(1'b0, 1'b0, 2'b10, 1'b0, 32'h3006, 64'd0, 5'd4, 64'd0, 0, "lw_misalign");
    run_op(1'b0, 1'b0, 2'b11, 1'b0, 32'h0010, 64'd0, 5'd4, 64'd0, 0, "ld_on_32");
    run_op(1'b1, 1'b0, 2'b11, 1'b0, 32'h0008, 64'd0, 5'd3, 64'h0123456789ABCDEF, 0, "ld_dword");
    vectors++;
    if (resp_data_b !== 64'h0123456789ABCDEF) begin
      miscompares++; $display("FAIL ld_dword_value: got %h want 0123456789ABCDEF", resp_data_b);
    end
    run_op(1'b1, 1'b0, 2'b01, 1'b1, 32'h0106, 64'd0, 5'd9, 64'h1111222233338001, 2, "lh64_off6");
    run_op(1'b1, 1'b1, 2'b00, 1'b0, 32'h0205, 64'h5A, 5'd0, 64'd0, 0, "sb64_off5");
  endtask

  task automatic test_random();
    bit          b64, we, sx;
    logic [1:0]  sz;
    logic [31:0] addr;
    for (int i = 0; i < 80; i++) begin
      b64  = 1'($urandom_range(0, 1));
      we   = 1'($urandom_range(0, 1));
      sx   = 1'($urandom_range(0, 1));
      sz   = 2'($urandom_range(0, 3));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << sz) - 32'd1);
      run_op(b64, we, sz, sx, addr, {$urandom, $urandom}, 5'($urandom),
             {$urandom, $urandom}, int'($urandom_range(0, 3)), "random");
      if (i % 5 == 0) begin
        @(negedge clk); mem_ack = 1'b1;
        @(negedge clk); mem_ack = 1'b0;
        vectors++;
        if (v_mem_req !== 1'b0 || v_resp_valid !== 1'b0) begin
          miscompares++; $display("FAIL idle_ack_ignored: got req=%b rv=%b want 0 0", v_mem_req, v_resp_valid);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] a_data, b_data;
    a_data = {32'd0, $urandom};
    b_data = {32'd0, $urandom};
    @(negedge clk);
    sel64 = 1'b0; en = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10;
    req_signext = 1'b0; req_addr = 32'h40; req_rd = 5'd1;
    @(negedge clk); mem_ack = 1'b1; mem_rdata = a_data;
    @(negedge clk);
    mem_ack = 1'b0; req_size = 2'b01; req_signext = 1'b1; req_addr = 32'h52; req_rd = 5'd2;
    #1;
    vectors++;
    if (v_resp_valid !== 1'b1 || v_resp_data !== m_load(4, 2'b10, 1'b0, 32'h40, a_data) ||
        v_resp_rd !== 5'd1 || v_stall !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_first: got rv=%b data=%h rd=%0d stall=%b", v_resp_valid, v_resp_data, v_resp_rd, v_stall);
    end
    @(negedge clk);
    vectors++;
    if (v_mem_req !== 1'b1 || v_mem_addr !== 32'h50 || v_resp_valid !== 1'b0) begin
      miscompares++; $display("FAIL b2b_second_req: got req=%b addr=%h rv=%b want 1 50 0", v_mem_req, v_mem_addr, v_resp_valid);
    end
    mem_ack = 1'b1; mem_rdata = b_data;
    @(negedge clk); mem_ack = 1'b0; req_valid = 1'b0; #1;
    vectors++;
    if (v_resp_valid !== 1'b1 || v_resp_data !== m_load(4, 2'b01, 1'b1, 32'h52, b_data) || v_resp_rd !== 5'd2) begin
      miscompares++; $display("FAIL b2b_second: got rv=%b data=%h rd=%0d", v_resp_valid, v_resp_data, v_resp_rd);
    end
  endtask

  task automatic test_en_freeze();
    logic [63:0] r;
    r = {32'd0, $urandom};
    @(negedge clk);
    sel64 = 1'b0; en = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_size = 2'b00;
    req_signext = 1'b0; req_addr = 32'h63; req_rd = 5'd9;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      en = 1'b0; mem_ack = 1'b1; mem_rdata = {32'd0, $urandom};
      #1;
      vectors++;
      if (v_mem_req !== 1'b1 || v_stall !== 1'b1 || v_resp_valid !== 1'b0) begin
        miscompares++; $display("FAIL freeze_hold: got req=%b stall=%b rv=%b want 1 1 0", v_mem_req, v_stall, v_resp_valid);
      end
    end
    @(negedge clk); en = 1'b1; mem_ack = 1'b1; mem_rdata = r;
    @(negedge clk); mem_ack = 1'b0; req_valid = 1'b0; en = 1'b0;
    vectors++;
    if (v_resp_valid !== 1'b1 || v_resp_data !== m_load(4, 2'b00, 1'b0, 32'h63, r)) begin
      miscompares++; $display("FAIL freeze_resp: got rv=%b data=%h", v_resp_valid, v_resp_data);
    end
    @(negedge clk);
    vectors++;
    if (v_resp_valid !== 1'b1) begin
      miscompares++; $display("FAIL freeze_pulse_held: got %b want 1", v_resp_valid);
    end
    en = 1'b1;
    @(negedge clk);
    vectors++;
    if (v_resp_valid !== 1'b0) begin
      miscompares++; $display("FAIL freeze_pulse_clear: got %b want 0", v_resp_valid);
    end
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk);
    sel64 = 1'b0; en = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10;
    req_signext = 1'b0; req_addr = 32'h70; req_rd = 5'd5;
    @(negedge clk);
    vectors++;
    if (v_mem_req !== 1'b1) begin
      miscompares++; $display("FAIL rst_mid_req: got %b want 1", v_mem_req);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0; mem_ack = 1'b1; mem_rdata = {32'd0, $urandom};
    #1;
    vectors++;
    if (v_mem_req !== 1'b0 || v_stall !== 1'b0) begin
      miscompares++; $display("FAIL rst_mid_drop: got req=%b stall=%b want 0 0", v_mem_req, v_stall);
    end
    @(negedge clk); mem_ack = 1'b0;
    vectors++;
    if (v_resp_valid !== 1'b0 || v_mem_req !== 1'b0) begin
      miscompares++; $display("FAIL rst_mid_late_ack: got rv=%b req=%b want 0 0", v_resp_valid, v_mem_req);
    end
    run_op(1'b0, 1'b0, 2'b01, 1'b1, 32'h7A, 64'd0, 5'd6, 64'h0000_8000, 1, "after_rst");
  endtask

  task automatic test_timeout();
    @(negedge clk);
    sel64 = 1'b0; en = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10;
    req_signext = 1'b0; req_addr = 32'h90; req_rd = 5'd8; mem_ack = 1'b0;
`ifdef MIPS_LSU_TIMEOUT_EN
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      en = !(i == 2 || i == 3);
      vectors++;
      if (v_mem_req !== 1'b1 || v_bus_err !== 1'b0) begin
        miscompares++; $display("FAIL timeout_wait: got req=%b berr=%b want 1 0 (cycle %0d)", v_mem_req, v_bus_err, i);
      end
    end
    @(negedge clk); req_valid = 1'b0; #1;
    vectors++;
    if (v_bus_err !== 1'b1 || v_mem_req !== 1'b0 || v_stall !== 1'b0 || v_resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_abort: got berr=%b req=%b stall=%b rv=%b want 1 0 0 0", v_bus_err, v_mem_req, v_stall, v_resp_valid);
    end
    @(negedge clk);
    vectors++;
    if (v_bus_err !== 1'b0) begin
      miscompares++; $display("FAIL timeout_pulse: got %b want 0", v_bus_err);
    end
`else
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++;
      if (v_mem_req !== 1'b1 || v_bus_err !== 1'b0) begin
        miscompares++; $display("FAIL no_timeout_wait: got req=%b berr=%b want 1 0", v_mem_req, v_bus_err);
      end
    end
    mem_ack = 1'b1; mem_rdata = 64'h0000_0000_CAFE_F00D;
    @(negedge clk); mem_ack = 1'b0; req_valid = 1'b0;
    vectors++;
    if (v_resp_valid !== 1'b1 || v_resp_data !== 64'h0000_0000_CAFE_F00D || v_bus_err !== 1'b0) begin
      miscompares++; $display("FAIL no_timeout_done: got rv=%b data=%h berr=%b", v_resp_valid, v_resp_data, v_bus_err);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_spec_vectors();
    test_random();
    test_back_to_back();
    test_en_freeze();
    test_reset_mid_access();
    test_timeout();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
